// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_pkg : shared types/constants for the UART transmit arbiter        |
// | Optional feature macro: UART_TX_TAG_EN (adds tag-frame states)         |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package uart_pkg;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT      = 3'd1,
`ifdef UART_TX_TAG_EN
    TAG_LAUNCH = 3'd2,
    TAG_WAIT   = 3'd3,
`endif
    LAUNCH     = 3'd4,
    WAIT_DONE  = 3'd5
  } arb_state_t;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int rr_wrap(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_rr_pick : combinational round-robin picker starting at rr_ptr     |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_vec,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] pick_id
);

  localparam int c_id_w = $clog2(NUM_REQ);

  logic [c_id_w-1:0] w_idx;

  // Scan from the farthest offset down so the nearest set bit to rr_ptr wins.
  always_comb begin
    any     = |req_vec;
    pick_id = '0;
    w_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_idx = c_id_w'(rr_wrap(int'(rr_ptr), off, NUM_REQ));
      if (req_vec[w_idx]) pick_id = w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin sharing of one UART transmitter between  |
// | NUM_REQ byte sources, one frame (or tag+data with UART_TX_TAG_EN).     |
// | Revision        : 1.0                                                  |
// +------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_idle,
  input  logic                       tx_done,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int                c_id_w    = $clog2(NUM_REQ);
  localparam int                c_wd_w    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYC - 1);
  localparam logic [c_wd_w-1:0] c_wd_max  = c_wd_w'(TIMEOUT_CYC);
  localparam logic [c_wd_w-1:0] c_wd_one  = c_wd_w'(1);

  arb_state_t          r_state, w_state_nxt;
  logic [c_id_w-1:0]   r_rr_ptr, w_rr_nxt, w_grant_nxt, w_pick;
  logic                w_any;
  logic [c_wd_w-1:0]   r_wdog, w_wdog_nxt, w_wdog_inc;
  logic                w_wdog_expired;
  logic [NUM_REQ-1:0]  w_ready_nxt;
  logic                w_tx_valid_nxt, w_timeout_nxt;
  logic [DATA_W-1:0]   w_tx_data_nxt, w_slot;
`ifdef UART_TX_TAG_EN
  logic [DATA_W-1:0]   r_byte, w_byte_nxt;
`endif

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_vec (req_valid),
    .rr_ptr  (r_rr_ptr),
    .any     (w_any),
    .pick_id (w_pick)
  );

  assign w_slot         = req_data[grant_id*DATA_W +: DATA_W];
  assign busy           = (r_state != IDLE);
  assign w_wdog_expired = (r_wdog == c_wd_last);
  assign w_wdog_inc     = (r_wdog == c_wd_max) ? r_wdog : r_wdog + c_wd_one;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = grant_id;
    w_rr_nxt       = r_rr_ptr;
    w_tx_data_nxt  = tx_data;
    w_wdog_nxt     = r_wdog;
    w_ready_nxt    = '0;
    w_tx_valid_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
`ifdef UART_TX_TAG_EN
    w_byte_nxt     = r_byte;
`endif
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_ready_nxt = NUM_REQ'(1) << grant_id;
        w_rr_nxt    = c_id_w'(rr_wrap(int'(grant_id), 1, NUM_REQ));
`ifdef UART_TX_TAG_EN
        w_byte_nxt    = w_slot;
        w_tx_data_nxt = DATA_W'(TAG_BASE) | DATA_W'(grant_id);
        w_state_nxt   = TAG_LAUNCH;
`else
        w_tx_data_nxt = w_slot;
        w_state_nxt   = LAUNCH;
`endif
      end
`ifdef UART_TX_TAG_EN
      TAG_LAUNCH: begin
        if (tx_idle) begin
          w_tx_valid_nxt = 1'b1;
          w_wdog_nxt     = '0;
          w_state_nxt    = TAG_WAIT;
        end
      end
      TAG_WAIT: begin
        // A tag-frame timeout abandons the data frame as well.
        if (tx_done) begin
          w_state_nxt = LAUNCH;
        end else if (w_wdog_expired) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_wdog_nxt = w_wdog_inc;
        end
      end
`endif
      LAUNCH: begin
        if (tx_idle) begin
          w_tx_valid_nxt = 1'b1;
          w_wdog_nxt     = '0;
          w_state_nxt    = WAIT_DONE;
`ifdef UART_TX_TAG_EN
          w_tx_data_nxt  = r_byte;
`endif
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          w_state_nxt = IDLE;
        end else if (w_wdog_expired) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else begin
          w_wdog_nxt = w_wdog_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rr_ptr    <= '0;
      grant_id    <= '0;
      tx_data     <= '0;
      r_wdog      <= '0;
      req_ready   <= '0;
      tx_valid    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_nxt;
      grant_id    <= w_grant_nxt;
      tx_data     <= w_tx_data_nxt;
      r_wdog      <= w_wdog_nxt;
      req_ready   <= w_ready_nxt;
      tx_valid    <= w_tx_valid_nxt;
      timeout_err <= w_timeout_nxt;
    end
  end

`ifdef UART_TX_TAG_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_byte <= '0;
    else       r_byte <= w_byte_nxt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Randomized bench for uart_tx_arbiter: a transaction-level model predicts every
// output each cycle, plus directed cases with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 50;
`ifdef UART_TX_TAG_EN
  localparam int FPG = 2;
`else
  localparam int FPG = 1;
`endif

  logic          clk = 1'b0;
  logic          nrst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_idle, tx_done, tx_valid;
  logic [DW-1:0] tx_data;
  logic [1:0]    grant_id;
  logic          busy, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_idle(tx_idle), .tx_done(tx_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transmitter stand-in ----------------
  int tx_mode  = 0;   // 0: done tx_delay cycles after launch, 1: random, 2: never done
  int tx_delay = 20;
  bit idle_low = 1'b0;
  int tx_cnt   = 0;

  initial begin : responder
    tx_idle = 1'b1;
    tx_done = 1'b0;
    forever begin
      tick();
      tx_done = 1'b0;
      if (tx_mode == 0) begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) tx_done = 1'b1;
        end
        if (tx_valid) tx_cnt = tx_delay;
        tx_idle = (tx_cnt == 0) && !idle_low;
      end else if (tx_mode == 1) begin
        tx_cnt  = 0;
        tx_idle = ($urandom_range(3) != 0);
        tx_done = ($urandom_range(19) == 0);
      end else begin
        tx_cnt  = 0;
        tx_idle = !idle_low;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [N-1:0]  e_ready;
  logic          e_txv, e_busy, e_to;
  logic [DW-1:0] e_data;
  logic [1:0]    e_gid;

  initial begin : model
    int rr, g, k;
    bit abort;
    logic [DW-1:0] frames[$];
    e_ready = '0; e_txv = 0; e_busy = 0; e_to = 0; e_data = '0; e_gid = '0;
    rr = 0;
    wait (nrst === 1'b1);
    forever begin
      e_busy = 1'b0; e_ready = '0; e_txv = 1'b0;
      @(posedge clk);
      e_to = 1'b0;
      if (req_valid == '0) continue;
      g = -1;
      for (int off = 0; off < N; off++)
        if (g < 0 && req_valid[(rr + off) % N]) g = (rr + off) % N;
      e_gid  = 2'(g);
      e_busy = 1'b1;
      @(posedge clk);
      rr = (g + 1) % N;
      e_ready = '0;
      e_ready[g] = 1'b1;
      frames.delete();
`ifdef UART_TX_TAG_EN
      frames.push_back(8'hA0 | 8'(g));
`endif
      frames.push_back(req_data[g*DW +: DW]);
      e_data = frames[0];
      abort  = 1'b0;
      for (int f = 0; f < frames.size() && !abort; f++) begin
        forever begin
          @(posedge clk);
          e_ready = '0;
          if (tx_idle) break;
        end
        e_txv  = 1'b1;
        e_data = frames[f];
        k = 0;
        forever begin
          @(posedge clk);
          e_txv = 1'b0;
          if (tx_done) break;
          if (k == TO - 1) begin
            e_to  = 1'b1;
            abort = 1'b1;
            break;
          end
          k++;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("req_ready",   req_ready,   e_ready);
      chk("tx_valid",    tx_valid,    e_txv);
      chk("tx_data",     tx_data,     e_data);
      chk("grant_id",    grant_id,    e_gid);
      chk("busy",        busy,        e_busy);
      chk("timeout_err", timeout_err, e_to);
    end
  end

  // ---------------- directed helpers ----------------
  logic [DW-1:0] seen[$];

  task automatic wait_idle();
    for (int i = 0; i < 1000 && busy; i++) tick();
    chk("drain_to_idle", busy, 0);
  endtask

  task automatic wait_txv(input bit hold, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!hold) req_valid = req_valid & ~req_ready;
      if (tx_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_count(input int ncyc, output int n_txv, output int n_to, output int n_rdy);
    n_txv = 0; n_to = 0; n_rdy = 0;
    repeat (ncyc) begin
      tick();
      if (tx_valid) begin
        n_txv++;
        seen.push_back(tx_data);
      end
      if (timeout_err) n_to++;
      if (|req_ready) n_rdy++;
      req_valid = req_valid & ~req_ready;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stim
    int n_txv, n_to, n_rdy, t0;
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] t2_first;

    // reset with every requester asserting
    nrst      = 1'b0;
    req_valid = '1;
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    repeat (5) begin
      tick();
      chk("reset_outputs_zero", {req_ready, tx_valid, tx_data, grant_id, busy, timeout_err}, 0);
    end

    // all requesters held: round-robin order
    tx_mode = 0; tx_delay = 20;
    nrst = 1'b1;
    for (int f = 0; f < 5 * FPG; f++) begin
      wait_txv(1'b1, ok);
      chk("rr_launch_seen", ok, 1);
      chk("rr_grant_order", grant_id, order[f / FPG]);
    end
    req_valid = '0;
    wait_idle();

    // single request: latency 2 to ready, 3 to launch
`ifdef UART_TX_TAG_EN
    t2_first = 8'hA2;
`else
    t2_first = 8'h5A;
`endif
    tick();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'h5A;
    tick();
    tick();
    chk("lat_ready_plus2", req_ready, 4'b0100);
    req_valid = '0;
    tick();
    chk("lat_txvalid_plus3", tx_valid, 1);
    chk("lat_txdata", tx_data, t2_first);
    wait_idle();

    // transmitter not idle: launch held off, then exactly one pulse
    idle_low = 1'b1;
    tick();
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 8'h3C;
    run_count(12, n_txv, n_to, n_rdy);
    chk("hold_no_launch", n_txv, 0);
    idle_low = 1'b0;
    run_count(6, n_txv, n_to, n_rdy);
    chk("hold_single_launch", n_txv, 1);
    wait_idle();

    // no tx_done ever: timeout exactly TO cycles after launch
    tx_mode = 2;
    tick();
    req_valid = 4'b0001;
    req_data[0 +: DW] = 8'hC7;
    wait_txv(1'b0, ok);
    chk("to_launch_seen", ok, 1);
    t0 = cyc;
    for (int i = 0; i < 100 && !timeout_err; i++) begin
      tick();
      req_valid = req_valid & ~req_ready;
    end
    chk("to_latency", cyc - t0, 50);
    chk("to_busy_low", busy, 0);
    tick();
    chk("to_pulse_one_cycle", timeout_err, 0);
    chk("to_busy_low_next", busy, 0);

    // tx_done on the last watchdog cycle wins over the timeout
    tx_mode = 0; tx_delay = TO - 1;
    tick();
    req_valid = 4'b1000;
    req_data[3*DW +: DW] = 8'h96;
    run_count(70, n_txv, n_to, n_rdy);
    chk("tie_no_timeout", n_to, 0);
    wait_idle();

    // tx_done one cycle late: timeout fires, late done ignored
    tx_delay = TO;
    tick();
    req_valid = 4'b1000;
    req_data[3*DW +: DW] = 8'h69;
    run_count(70, n_txv, n_to, n_rdy);
    chk("late_done_timeout", n_to, 1);
    chk("late_done_ready_once", n_rdy, 1);
    wait_idle();

`ifdef UART_TX_TAG_EN
    tx_delay = 10;
    seen.delete();
    tick();
    req_valid = 4'b1000;
    req_data[3*DW +: DW] = 8'h11;
    run_count(60, n_txv, n_to, n_rdy);
    chk("tag_frames", n_txv, 2);
    chk("tag_first", seen[0], 8'hA3);
    chk("tag_second", seen[1], 8'h11);
    chk("tag_ready_once", n_rdy, 1);
    wait_idle();
`endif

    // randomized traffic against the model
    tx_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          req_valid[i] = ($urandom_range(1) == 1);
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (!req_valid[i]) begin
          if ($urandom_range(7) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end else if (!(busy && grant_id == 2'(i)) && $urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    tx_mode = 0; tx_delay = 5;
    wait_idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
